// File: rtl/cheshire_uart_tx.sv
// cheshire_uart_tx: 8N1-style UART transmitter with a byte FIFO and a programmable baud divider.
// Define CHESHIRE_UART_TX_PARITY_EN to add a parity bit (parity_odd_i selects odd parity).
module cheshire_uart_tx #(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned StopBits  = 1,
  parameter int unsigned DivWidth  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DivWidth-1:0]        baud_div_i,
  input  logic [7:0]                 data_i,
  input  logic                       valid_i,
`ifdef CHESHIRE_UART_TX_PARITY_EN
  input  logic                       parity_odd_i,
`endif
  output logic                       ready_o,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic [$clog2(FifoDepth):0] level_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl  = LvlW'(FifoDepth);
  localparam logic            LastStop = 1'(StopBits - 1);

  if (StopBits != 1 && StopBits != 2) begin : gen_stop_chk
    $fatal(1, "cheshire_uart_tx: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gen_depth_chk
    $fatal(1, "cheshire_uart_tx: FifoDepth must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef CHESHIRE_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            push, pop, load, bit_end;

  state_e              state_q, state_d;
  logic [DivWidth-1:0] div_q, div_d;
  logic [DivWidth-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic                stop_q, stop_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
`ifdef CHESHIRE_UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign ready_o = (level_q != FullLvl);
  assign push    = valid_i && ready_o;
  assign pop     = load;
  assign level_o = level_q;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != StIdle) || (level_q != '0);
  assign bit_end = (cnt_q == div_q);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because FifoDepth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    load    = 1'b0;
`ifdef CHESHIRE_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      StIdle: load = (level_q != '0);
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef CHESHIRE_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef CHESHIRE_UART_TX_PARITY_EN
      StParity: begin
        tx_d = par_q;
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (stop_q == LastStop) begin
            stop_d = 1'b0;
            // Back-to-back frames: pop straight into the next start bit.
            if (level_q != '0) load = 1'b1;
            else               state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StStart;
      shift_d = mem_q[rd_ptr_q];
      div_d   = baud_div_i;
      cnt_d   = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
`ifdef CHESHIRE_UART_TX_PARITY_EN
      par_d   = (^mem_q[rd_ptr_q]) ^ parity_odd_i;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef CHESHIRE_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef CHESHIRE_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_cheshire_uart_tx.sv
// Bench for cheshire_uart_tx: directed and random pushes checked every cycle against a
// frame-level line model; instance 0 uses one stop bit, instance 1 uses two.
module tb_cheshire_uart_tx;

  localparam int Depth  = 4;
  localparam int MaxCyc = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = '0;
  logic [7:0]  data = '0;
  logic        valid = 1'b0;
`ifdef CHESHIRE_UART_TX_PARITY_EN
  logic        parity_odd = 1'b0;
`endif

  logic       ready0, tx0, busy0, ready1, tx1, busy1;
  logic [2:0] level0, level1;

  int checks = 0;
  int errors = 0;
  int t_cur  = 0;

  // Model: per-instance byte queue, end time of the last scheduled frame, expected line.
  logic [7:0] pq [2][16];
  int         pq_head [2];
  int         pq_cnt [2];
  int         line_end [2];
  logic       exp_tx [2][MaxCyc];
  logic       accepted [2];
  logic [7:0] fill [6];
  int         idx, low0, low1;

  always #5 clk = ~clk;

  cheshire_uart_tx #(.FifoDepth(Depth), .StopBits(1), .DivWidth(16)) dut0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .baud_div_i   (baud_div),
    .data_i       (data),
    .valid_i      (valid),
`ifdef CHESHIRE_UART_TX_PARITY_EN
    .parity_odd_i (parity_odd),
`endif
    .ready_o      (ready0),
    .tx_o         (tx0),
    .busy_o       (busy0),
    .level_o      (level0)
  );

  cheshire_uart_tx #(.FifoDepth(Depth), .StopBits(2), .DivWidth(16)) dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .baud_div_i   (baud_div),
    .data_i       (data),
    .valid_i      (valid),
`ifdef CHESHIRE_UART_TX_PARITY_EN
    .parity_odd_i (parity_odd),
`endif
    .ready_o      (ready1),
    .tx_o         (tx1),
    .busy_o       (busy1),
    .level_o      (level1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t_cur, got, exp);
    end
  endtask

  task automatic model_reset();
    t_cur = 0;
    for (int i = 0; i < 2; i++) begin
      pq_head[i]  = 0;
      pq_cnt[i]   = 0;
      line_end[i] = -100;
      accepted[i] = 1'b0;
      for (int c = 0; c < MaxCyc; c++) exp_tx[i][c] = 1'b1;
    end
  endtask

  // Line picture of one frame starting at cycle 'start', each bit held div+1 cycles.
  task automatic put_frame(input int i, input int start, input logic [7:0] b, input int sb,
                           input logic par);
    int   p, nb;
    logic v;
    p  = int'(baud_div) + 1;
    nb = 9 + sb;
`ifdef CHESHIRE_UART_TX_PARITY_EN
    nb = nb + 1;
`endif
    for (int k = 0; k < nb; k++) begin
      if (k == 0)                       v = 1'b0;
      else if (k <= 8)                  v = b[k-1];
      else if (k == 9 && nb == 10 + sb) v = par;
      else                              v = 1'b1;
      for (int c = 0; c < p; c++)
        if (start + k * p + c < MaxCyc) exp_tx[i][start + k * p + c] = v;
    end
    line_end[i] = start + nb * p;
  endtask

  // One clock edge of the model: pop if idle or at the end of the last stop bit, then push.
  task automatic model_edge(input int i, input int sb);
    logic       rdy, par;
    logic [7:0] b;
    rdy = (pq_cnt[i] != Depth);
    accepted[i] = 1'b0;
    if (pq_cnt[i] > 0 && t_cur >= line_end[i] - 1) begin
      b = pq[i][pq_head[i]];
`ifdef CHESHIRE_UART_TX_PARITY_EN
      par = (^b) ^ parity_odd;
`else
      par = 1'b0;
`endif
      put_frame(i, t_cur + 1, b, sb, par);
      pq_head[i] = (pq_head[i] + 1) % 16;
      pq_cnt[i]--;
    end
    if (valid && rdy) begin
      pq[i][(pq_head[i] + pq_cnt[i]) % 16] = data;
      pq_cnt[i]++;
      accepted[i] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    t_cur++;
    if (t_cur >= MaxCyc) begin
      $display("FAIL cycle_budget at t=%0d: got %0d expected below %0d", t_cur, t_cur, MaxCyc);
      $fatal(1, "cycle budget exhausted");
    end
    model_edge(0, 1);
    model_edge(1, 2);
    @(negedge clk);
    check("tx0",    32'(tx0),    32'(exp_tx[0][t_cur]));
    check("level0", 32'(level0), pq_cnt[0]);
    check("ready0", 32'(ready0), 32'(pq_cnt[0] != Depth));
    check("busy0",  32'(busy0),  32'(pq_cnt[0] > 0 || t_cur < line_end[0] - 1));
    check("tx1",    32'(tx1),    32'(exp_tx[1][t_cur]));
    check("level1", 32'(level1), pq_cnt[1]);
    check("ready1", 32'(ready1), 32'(pq_cnt[1] != Depth));
    check("busy1",  32'(busy1),  32'(pq_cnt[1] > 0 || t_cur < line_end[1] - 1));
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx0",    32'(tx0),    32'd1);
    check("rst_ready0", 32'(ready0), 32'd1);
    check("rst_busy0",  32'(busy0),  32'd0);
    check("rst_level0", 32'(level0), 32'd0);
    check("rst_tx1",    32'(tx1),    32'd1);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_busy1",  32'(busy1),  32'd0);
    check("rst_level1", 32'(level1), 32'd0);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Single 0x55 frame, 4-cycle bits.
    do_reset();
    baud_div = 16'd3;
    data     = 8'h55;
    valid    = 1'b1;
    low0 = 0;
    low1 = 0;
    for (int n = 0; n < 60; n++) begin
      cycle();
      valid = 1'b0;
      if (tx0 == 1'b0) low0++;
      if (tx1 == 1'b0) low1++;
      if (t_cur == 2) check("single_pre_start", 32'(tx0), 32'd1);
      if (t_cur == 3) check("single_start", 32'(tx0), 32'd0);
    end
    check("single_low0", low0, 32'd20);
    check("single_low1", low1, 32'd20);
    check("single_busy_end", 32'(busy0), 32'd0);

    // Hold valid with six bytes at 1-cycle bits; FIFO fills while the first frame runs.
    do_reset();
    baud_div = 16'd0;
    idx = 0;
    for (int n = 0; n < 120; n++) begin
      valid = (idx < 6);
      data  = fill[(idx < 6) ? idx : 5];
      cycle();
      if (accepted[0]) idx++;
      if (t_cur == 8) begin
        check("full_level", 32'(level0), 32'd4);
        check("full_ready", 32'(ready0), 32'd0);
      end
    end

    // Divisor change mid-frame: 0xC3 at 8-cycle bits, then 0x3C at 2-cycle bits.
    do_reset();
    baud_div = 16'd7;
    data     = 8'hC3;
    valid    = 1'b1;
    cycle();
    data = 8'h3C;
    cycle();
    valid = 1'b0;
    for (int n = 0; n < 128; n++) begin
      cycle();
      if (t_cur == 30) baud_div = 16'd1;
      if (t_cur == 35) check("div_old_d3", 32'(tx0), 32'd0);
      if (t_cur == 65) check("div_old_d6", 32'(tx0), 32'd1);
      if (t_cur == 88) check("div_new_d1", 32'(tx0), 32'd0);
      if (t_cur == 89) check("div_new_d2", 32'(tx0), 32'd1);
    end

    // Two stop bits (instance 1): 0xA3 then 0x0F at 2-cycle bits, 22-cycle frames.
    do_reset();
    baud_div = 16'd1;
    data     = 8'hA3;
    valid    = 1'b1;
    cycle();
    data = 8'h0F;
    cycle();
    valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      cycle();
      if (t_cur == 21) check("stop2_gap_first", 32'(tx1), 32'd1);
      if (t_cur == 24) check("stop2_gap_last", 32'(tx1), 32'd1);
      if (t_cur == 25) check("stop2_next_start", 32'(tx1), 32'd0);
    end

    // Reset during data bit 3 with two bytes queued.
    do_reset();
    baud_div = 16'd3;
    valid    = 1'b1;
    for (int n = 0; n < 3; n++) begin
      data = 8'(8'hA5 + n);
      cycle();
    end
    valid = 1'b0;
    for (int n = 0; n < 17; n++) cycle();
    #2 rst = 1'b1;
    #1;
    check("async_tx0",    32'(tx0),    32'd1);
    check("async_level0", 32'(level0), 32'd0);
    check("async_tx1",    32'(tx1),    32'd1);
    check("async_level1", 32'(level1), 32'd0);
    do_reset();
    for (int n = 0; n < 100; n++) cycle();

`ifdef CHESHIRE_UART_TX_PARITY_EN
    // Parity of 0x07 at 1-cycle bits: even gives 1, odd gives 0.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      baud_div   = 16'd0;
      parity_odd = 1'(k);
      data       = 8'h07;
      valid      = 1'b1;
      for (int n = 0; n < 20; n++) begin
        cycle();
        valid = 1'b0;
        if (t_cur == 12) check("parity_bit", 32'(tx0), 32'(k == 0));
      end
    end
`endif

    // Random traffic at three push densities with occasional divisor changes.
    for (int tr = 0; tr < 3; tr++) begin
      do_reset();
      baud_div = 16'($urandom_range(0, 3));
      for (int n = 0; n < 1500; n++) begin
        valid = ($urandom_range(0, 7) < 32'(1 + 3 * tr));
        data  = 8'($urandom);
`ifdef CHESHIRE_UART_TX_PARITY_EN
        parity_odd = 1'($urandom);
`endif
        if ($urandom_range(0, 199) == 0) baud_div = 16'($urandom_range(0, 3));
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
